// File: rtl/lcd_timing_generator.sv
// LCD panel timing: pixel enable from a clock divider, raster position counters,
// and registered sync / data-enable / start-of-blanking outputs.
module lcd_timing_generator #(
   parameter int   DIVIDER  = 4,
   parameter int   H_ACTIVE = 800,
   parameter int   H_FRONT  = 40,
   parameter int   H_SYNC   = 48,
   parameter int   H_BACK   = 40,
   parameter int   V_ACTIVE = 480,
   parameter int   V_FRONT  = 13,
   parameter int   V_SYNC   = 3,
   parameter int   V_BACK   = 29,
   parameter logic HS_POL   = 1'b0,
   parameter logic VS_POL   = 1'b0
) (
   input  logic        clock,
   input  logic        reset,
   output logic        lcd_tick,
   output logic        lcd_clk,
   output logic        lcd_next_frame,
   output logic        lcd_data_enable,
   output logic        lcd_hs,
   output logic        lcd_vs,
   output logic [10:0] lcd_x,
   output logic [9:0]  lcd_y,
   output logic [15:0] frame_count
);

   localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
   localparam int DIV_W   = (DIVIDER > 2) ? $clog2(DIVIDER) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIVIDER - 1);
   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(DIVIDER / 2);

   localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
   localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE);
   localparam logic [10:0] HS_START   = 11'(H_ACTIVE + H_FRONT);
   localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
   localparam logic [9:0]  V_ACT_END  = 10'(V_ACTIVE);
   localparam logic [9:0]  VS_START   = 10'(V_ACTIVE + V_FRONT);
   localparam logic [9:0]  VS_END     = 10'(V_ACTIVE + V_FRONT + V_SYNC);

   generate
      if (DIVIDER < 2 || DIVIDER > 256) begin : g_bad_divider
         $error("lcd_timing_generator: DIVIDER must be in 2..256");
      end
      if (H_TOTAL > 2048) begin : g_bad_h_total
         $error("lcd_timing_generator: horizontal total exceeds 2048");
      end
      if (V_TOTAL > 1024) begin : g_bad_v_total
         $error("lcd_timing_generator: vertical total exceeds 1024");
      end
      if (H_ACTIVE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1) begin : g_bad_h_param
         $error("lcd_timing_generator: horizontal timing values must be at least 1");
      end
      if (V_ACTIVE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_bad_v_param
         $error("lcd_timing_generator: vertical timing values must be at least 1");
      end
   endgenerate

   logic [DIV_W-1:0] r_div;
   logic             r_tick;
   logic             r_clk;
   logic [10:0]      r_h;
   logic [9:0]       r_v;
   logic             r_de;
   logic             r_hs;
   logic             r_vs;
   logic             r_next_frame;
   logic [15:0]      r_frame_count;

   logic [DIV_W-1:0] w_div_next;
   logic [10:0]      w_h_next;
   logic [9:0]       w_v_next;
   logic             w_frame_start;

   always_comb begin
      w_div_next = (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
   end

   // Position only moves on the edge that closes a tick cycle; otherwise it holds.
   always_comb begin
      w_h_next = r_h;
      w_v_next = r_v;
      if (r_tick) begin
         if (r_h == H_LAST) begin
            w_h_next = '0;
            w_v_next = (r_v == V_LAST) ? '0 : r_v + 10'd1;
         end else begin
            w_h_next = r_h + 11'd1;
         end
      end
   end

   // Only a tick can land on (0, V_ACTIVE); the reset state sits there without a tick.
   always_comb begin
      w_frame_start = r_tick && (w_h_next == '0) && (w_v_next == V_ACT_END);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_div         <= '0;
         r_tick        <= 1'b0;
         r_clk         <= 1'b0;
         r_h           <= '0;
         r_v           <= V_ACT_END;
         r_de          <= 1'b0;
         r_hs          <= ~HS_POL;
         r_vs          <= ~VS_POL;
         r_next_frame  <= 1'b0;
         r_frame_count <= '0;
      end else begin
         r_div         <= w_div_next;
         r_tick        <= (w_div_next == '0);
         r_clk         <= (w_div_next >= DIV_HALF);
         r_h           <= w_h_next;
         r_v           <= w_v_next;
         r_de          <= (w_h_next < H_ACT_END) && (w_v_next < V_ACT_END);
         r_hs          <= ((w_h_next >= HS_START) && (w_h_next < HS_END)) ? HS_POL : ~HS_POL;
         r_vs          <= ((w_v_next >= VS_START) && (w_v_next < VS_END)) ? VS_POL : ~VS_POL;
         r_next_frame  <= w_frame_start;
         if (w_frame_start) begin
            r_frame_count <= r_frame_count + 16'd1;
         end
      end
   end

   assign lcd_tick        = r_tick;
   assign lcd_clk         = r_clk;
   assign lcd_next_frame  = r_next_frame;
   assign lcd_data_enable = r_de;
   assign lcd_hs          = r_hs;
   assign lcd_vs          = r_vs;
   assign lcd_x           = r_h;
   assign lcd_y           = r_v;
   assign frame_count     = r_frame_count;

endmodule

// File: doc/lcd_timing_generator.md
Name: lcd_timing_generator

Overview:
- Generates all LCD panel timing from the system clock: a pixel-clock enable (`lcd_tick`), the panel pixel clock, HSYNC/VSYNC, data enable, and a one-cycle start-of-blanking pulse (`lcd_next_frame`).
- Sits directly upstream of the frame-buffer streamer, which consumes `lcd_tick`, `lcd_next_frame` and `lcd_data_enable`.
- The HSYNC/VSYNC/clock outputs also drive the panel pins directly.

Parameters:
- DIVIDER, 4: system clocks per pixel; legal range is 2..256.
- H_ACTIVE, 800: visible pixels per line.
- H_FRONT, 40: horizontal front porch, in pixels.
- H_SYNC, 48: HSYNC width, in pixels.
- H_BACK, 40: horizontal back porch, in pixels.
- V_ACTIVE, 480: visible lines per frame.
- V_FRONT, 13: vertical front porch, in lines.
- V_SYNC, 3: VSYNC width, in lines.
- V_BACK, 29: vertical back porch, in lines.
- HS_POL, 0: asserted level of `lcd_hs`.
- VS_POL, 0: asserted level of `lcd_vs`.
- Parameter constraints: every porch and sync value is at least 1, and every ACTIVE value is at least 1.

Ports:
- clock  in  1  system clock; the only clock in the block.
- reset  in  1  asynchronous, active-high reset.
- lcd_tick  out  1  one-cycle pixel enable, high once every DIVIDER clocks.
- lcd_clk  out  1  panel pixel clock at clock/DIVIDER.
- lcd_next_frame  out  1  one-cycle pulse at the start of vertical blanking.
- lcd_data_enable  out  1  high while the current pixel is visible.
- lcd_hs  out  1  horizontal sync.
- lcd_vs  out  1  vertical sync.
- lcd_x  out  11  current horizontal position h.
- lcd_y  out  10  current vertical position v.
- frame_count  out  16  completed frames; wraps modulo 2^16.

Behaviour:
- Clocking and reset: one clock, `clock`; reset `reset` is asynchronous and active-high.
- Derived constants:
  - H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK.
  - V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK.
  - Compute both at 32 bits. H_TOTAL must be at most 2048 and V_TOTAL at most 1024; violating either is a parameter error.
- Divider counter d:
  - Counts 0..DIVIDER-1, incrementing every clock and wrapping to 0.
  - `lcd_tick` is registered and high exactly in the cycles where d==0.
  - `lcd_clk` is registered: 0 for d < DIVIDER/2 (integer division), 1 otherwise.
- Position counters (h, v):
  - They advance only on an edge where `lcd_tick` is 1.
  - h increments; at H_TOTAL-1 it wraps to 0 and v increments.
  - v wraps from V_TOTAL-1 to 0.
  - All outputs derived from h and v are registered from the new h and v, so they change in the cycle after a tick (d==1) and hold stable until the next tick.
- Per-line layout: active first, then front porch, sync, back porch.
  - `lcd_data_enable` = (h < H_ACTIVE) && (v < V_ACTIVE).
  - HSYNC is asserted for H_ACTIVE+H_FRONT <= h < H_ACTIVE+H_FRONT+H_SYNC.
  - When asserted, `lcd_hs` = HS_POL; otherwise it equals !HS_POL.
- Per-frame layout: VSYNC is asserted for V_ACTIVE+V_FRONT <= v < V_ACTIVE+V_FRONT+V_SYNC, using the same polarity rule with VS_POL.
  - VSYNC therefore changes only together with h becoming 0.
- `lcd_next_frame`:
  - High for exactly one cycle, the cycle after the tick that moves (h, v) to (0, V_ACTIVE).
  - `frame_count` increments on that same edge.
  - This gives the downstream streamer the whole vertical blanking interval to flush and prefetch. No other position produces the pulse.
- `lcd_x` and `lcd_y` mirror h and v exactly.
- Reset values:
  - d=0, h=0, v=V_ACTIVE; blanking starts immediately, so no visible pixel appears before a full blanking interval.
  - `lcd_tick`=0, `lcd_clk`=0, `lcd_data_enable`=0, `lcd_next_frame`=0.
  - `lcd_hs`=!HS_POL, `lcd_vs`=!VS_POL, `frame_count`=0.
  - No `lcd_next_frame` pulse is emitted as a result of reset itself.
  - After reset is released, the first `lcd_tick` occurs after DIVIDER clocks.
- Reset mid-frame: everything returns to the reset values asynchronously. Counting resumes from blanking; no partial frame is completed.
- Simultaneous events: the h wrap, the v wrap, the VSYNC edge, the DE edge and the next_frame pulse all fall out of the same (h, v) update. None of them ever requires an extra tick.

Test Plan:
Bench parameters: DIVIDER=4, H 4/1/2/1 (H_TOTAL=8), V 3/1/1/1 (V_TOTAL=6), HS_POL=VS_POL=0. One frame is 48 ticks = 192 clocks.
- Reset release, then run 8 clocks -> `lcd_tick` high only in clock 4 and clock 8.
  - `lcd_clk` follows the pattern 0,0,1,1.
  - `lcd_data_enable`=0 and `lcd_vs`=1 throughout.
- Run from reset until the first active line (v=0), then observe one line -> DE high for exactly 16 clocks (4 pixels), rising 1 clock after the tick.
  - `lcd_hs` is low for 8 clocks, starting 1 clock after the tick that sets h=5.
- Run two full frames -> exactly 2 `lcd_next_frame` pulses, 192 clocks apart.
  - Each pulse is 1 clock wide with `lcd_x`=0 and `lcd_y`=3.
  - `frame_count` reads 2 at the end.
- Vertical sync -> `lcd_vs` low only while `lcd_y`==4 (32 clocks), edges aligned with `lcd_x` becoming 0.
  - DE is 0 for all of v = 3..5.
- Assert `reset` mid-line at v=1, h=2 -> all outputs take their reset values in the same cycle, without waiting for a clock edge.
  - After release, the next DE rise occurs 3 lines later (24 ticks).
- Count DE-high ticks over one frame -> exactly 12 (H_ACTIVE×V_ACTIVE).
  - `frame_count` wraps from 0xFFFF to 0 when forced via a long run or a backdoor write.
